// File: rtl/vc_trigger_seq.sv
// Turns three raw active-low pushbuttons into mutually exclusive segment triggers
// t1/t2/t3 for the voice-corruptor address counter. Each trigger is held for its segment length.
module vc_trigger_seq #(
  parameter logic [19:0] DB_CYCLES = 20'd500000,
  parameter logic [12:0] LEN1      = 13'd394,
  parameter logic [12:0] LEN2      = 13'd256,
  parameter logic [12:0] LEN3      = 13'd128,
  parameter logic        LOOP_EN   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_n,
  output logic       t1,
  output logic       t2,
  output logic       t3,
  output logic       busy,
  output logic [1:0] sel
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PLAY     = 2'd1;
  localparam logic [1:0] S_GAP      = 2'd2;
  localparam logic [1:0] S_WAIT_REL = 2'd3;

  logic [2:0]       sync1, sync2, key_act;
  logic [2:0][19:0] db_cnt;
  logic [2:0]       db_lvl, db_lvl_d, press;
  logic [1:0]       state, state_d;
  logic [12:0]      cnt, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [2:0]       t_q, t_d;
  logic             held;

  // Both synchroniser stages reset to the released level so no edge appears on release.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign key_act = ~sync2;

  // The debounced level flips after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_lvl   <= '0;
      db_lvl_d <= '0;
      press    <= '0;
    end else begin
      db_lvl_d <= db_lvl;
      press    <= db_lvl & ~db_lvl_d;
      for (int i = 0; i < 3; i++) begin
        if (key_act[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_CYCLES - 20'd1) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= ~db_lvl[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end

  function automatic logic [12:0] len_m1(input logic [1:0] s);
    case (s)
      2'd1:    len_m1 = LEN1 - 13'd1;
      2'd2:    len_m1 = LEN2 - 13'd1;
      default: len_m1 = LEN3 - 13'd1;
    endcase
  endfunction

  always_comb begin
    case (sel_q)
      2'd1:    held = db_lvl[0];
      2'd2:    held = db_lvl[1];
      2'd3:    held = db_lvl[2];
      default: held = 1'b0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sel_d   = sel_q;
    case (state)
      S_IDLE: begin
        if (|press) begin
          sel_d   = press[0] ? 2'd1 : (press[1] ? 2'd2 : 2'd3);
          cnt_d   = len_m1(sel_d);
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (cnt == 13'd0) begin
          if (LOOP_EN && held) begin
            state_d = S_GAP;
          end else begin
            state_d = S_WAIT_REL;
            sel_d   = 2'd0;
          end
        end else begin
          cnt_d = cnt - 13'd1;
        end
      end
      S_GAP: begin
        cnt_d   = len_m1(sel_q);
        state_d = S_PLAY;
      end
      S_WAIT_REL: begin
        if (db_lvl == 3'b000) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Triggers are decoded from next state so they come straight out of flops.
  always_comb begin
    t_d = 3'b000;
    if (state_d == S_PLAY) begin
      case (sel_d)
        2'd1:    t_d = 3'b001;
        2'd2:    t_d = 3'b010;
        2'd3:    t_d = 3'b100;
        default: t_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      sel_q <= '0;
      t_q   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sel_q <= sel_d;
      t_q   <= t_d;
    end
  end

  assign t1   = t_q[0];
  assign t2   = t_q[1];
  assign t3   = t_q[2];
  assign sel  = sel_q;
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_vc_trigger_seq.sv
// Directed bench for vc_trigger_seq with a short debounce: one-shot instance for the
// press/priority/bounce/reset cases, a second LOOP_EN instance for repeat-while-held.
module tb_vc_trigger_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] key_n, key_l;
  logic       t1, t2, t3, busy;
  logic [1:0] sel;
  logic       l_t1, l_t2, l_t3, l_busy;
  logic [1:0] l_sel;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rel_at = -1;

  typedef struct {
    logic [2:0] keys;
    logic [1:0] exp_sel;
    logic [2:0] exp_t;
    int         exp_len;
  } vec_t;

  vec_t vecs [6];

  vc_trigger_seq #(.DB_CYCLES(20'd4)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .t1(t1), .t2(t2), .t3(t3), .busy(busy), .sel(sel)
  );

  vc_trigger_seq #(.DB_CYCLES(20'd4), .LOOP_EN(1'b1)) u_dut_loop (
    .clk(clk), .rst_n(rst_n), .key_n(key_l),
    .t1(l_t1), .t2(l_t2), .t3(l_t3), .busy(l_busy), .sel(l_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc == rel_at) key_n = 3'b111;
  endtask

  // Returns at the first negedge where a trigger is seen; expects 8 cycles from the key drive.
  task automatic wait_rise(input string name);
    int lat;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ({t3, t2, t1} != 3'b000) begin
        lat = i;
        break;
      end
    end
    check(name, lat, 8);
  endtask

  task automatic run_high(input string name, input logic [2:0] exp_t,
                          input logic [1:0] exp_sel, input int exp_len);
    int hi, err;
    hi  = 0;
    err = 0;
    while ({t3, t2, t1} != 3'b000 && hi < 9000) begin
      if ({t3, t2, t1} != exp_t || sel != exp_sel || busy != 1'b1) err++;
      hi++;
      tick();
    end
    check({name, "_len"}, hi, exp_len);
    check({name, "_onehot_sel"}, err, 0);
    check({name, "_waitrel_busy"}, int'(busy), 1);
    check({name, "_waitrel_sel"}, int'(sel), 0);
    tick();
    check({name, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    int hit, err, first_bad;
    logic exp_t3;

    vecs[0] = '{3'b110, 2'd1, 3'b001, 394};
    vecs[1] = '{3'b101, 2'd2, 3'b010, 256};
    vecs[2] = '{3'b011, 2'd3, 3'b100, 128};
    vecs[3] = '{3'b000, 2'd1, 3'b001, 394};
    vecs[4] = '{3'b001, 2'd2, 3'b010, 256};
    vecs[5] = '{3'b010, 2'd1, 3'b001, 394};

    key_n = 3'b111;
    key_l = 3'b111;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_t", int'({t3, t2, t1}), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_sel", int'(sel), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single presses and simultaneous-press priority.
    for (int v = 0; v < 6; v++) begin
      key_n  = vecs[v].keys;
      cyc    = 0;
      rel_at = 10;
      wait_rise($sformatf("vec%0d_latency", v));
      run_high($sformatf("vec%0d", v), vecs[v].exp_t, vecs[v].exp_sel, vecs[v].exp_len);
      repeat (5) tick();
    end
    rel_at = -1;

    // Bounce shorter than the debounce window never triggers.
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      key_n = ((i / 2) % 2 == 0) ? 3'b101 : 3'b111;
      tick();
      if (busy || t2) hit++;
    end
    key_n = 3'b111;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || t2) hit++;
    end
    check("bounce_no_trigger", hit, 0);

    // Reset in the middle of a t2 segment, key still held afterwards.
    key_n = 3'b101;
    wait_rise("rst_first_latency");
    hit = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!t2) hit++;
    end
    check("rst_t2_held_before", hit, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_t", int'({t3, t2, t1}), 0);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_sel", int'(sel), 0);
    check("rst_async_loop_busy", int'(l_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_rise("rst_redebounce_latency");
    key_n = 3'b111;
    run_high("rst_resegment", 3'b010, 2'd2, 256);
    repeat (5) tick();

    // Repeat-while-held on the LOOP_EN instance: 128 high, 1 gap, ... finishing the segment in progress.
    err = 0;
    first_bad = -1;
    key_l = 3'b011;
    for (int k = 1; k <= 450; k++) begin
      @(negedge clk);
      exp_t3 = (k >= 8) && (k <= 393) && (((k - 8) % 129) != 128);
      if (l_t3 != exp_t3 || l_t1 || l_t2) begin
        err++;
        if (first_bad < 0) first_bad = k;
      end
      if (k == 136) begin
        check("loop_gap_sel", int'(l_sel), 3);
        check("loop_gap_busy", int'(l_busy), 1);
      end
      if (k == 300) key_l = 3'b111;
    end
    check("loop_pattern_errors", err, 0);
    if (err != 0) check("loop_first_bad_cycle", first_bad, 0);
    check("loop_final_busy", int'(l_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
